pcache_arb: RTL and testbench
=============================

PCACHE_ARB -- requirements
Module: pcache_arb

Interface
REQ-001 Parameter ENTRIES, 512: number of parameter-cache entries; legal tags are 0..ENTRIES-1.
REQ-002 Parameter STARVE_LIMIT, 3: consecutive read grants allowed while a write waits.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 flush  in  1  one-cycle pulse at tile start; invalidates all entries.
REQ-006 wr_req  in  1  writer request; level, held until wr_ack.
REQ-007 wr_tag  in  12  writer target tag; stable while wr_req=1.
REQ-008 wr_ack  out  1  write granted this cycle; combinational.
REQ-009 rd_req  in  1  reader request; level, held until rd_ack.
REQ-010 rd_tag  in  12  reader target tag; stable while rd_req=1.
REQ-011 rd_ack  out  1  read granted this cycle; combinational.
REQ-012 prim_tag  out  12  shared cache address; combinational.
REQ-013 pcache_write  out  1  cache write enable; combinational.
REQ-014 rd_valid  out  1  registered; cache outputs hold the granted read's data.
REQ-015 rd_hit  out  1  registered with rd_valid; the read entry was valid.
REQ-016 tag_err  out  1  registered one-cycle pulse; a granted tag was >= ENTRIES.
REQ-017 valid_count  out  10  number of valid entries.
REQ-018 flushing  out  1  FSM is in FLUSH.

Function
REQ-019 FSM has two states, RUN and FLUSH; flush=1 in RUN moves the FSM to FLUSH; FLUSH returns to RUN after exactly one cycle.
REQ-020 In FLUSH, all valid bits and valid_count clear, and wr_ack, rd_ack and pcache_write are 0.
REQ-021 flush=1 in RUN blocks grants that same cycle (flush wins over simultaneous requests).
REQ-022 In RUN with a single requester, that requester is granted in the same cycle.
REQ-023 In RUN with both requesting, read wins unless starve_cnt equals STARVE_LIMIT, in which case write wins.
REQ-024 starve_cnt increments on a read grant while wr_req=1, and clears on any write grant or when wr_req=0.
REQ-025 At most one grant per cycle; prim_tag carries the granted tag, or 0 when nothing is granted.
REQ-026 On a write grant with tag < ENTRIES: pcache_write=1, the valid bit is set, and valid_count increments only if the bit was previously clear.
REQ-027 On any grant with tag >= ENTRIES: pcache_write stays 0, the valid bits are unchanged, the request is still acked, and tag_err pulses on the next cycle.
REQ-028 A read grant in cycle N drives rd_valid=1 in cycle N+1 only, with rd_hit equal to the valid bit sampled in cycle N.
REQ-029 A read of a tag in cycle N+1 following a write grant to the same tag in cycle N returns the new data and rd_hit=1.
REQ-030 valid_count never exceeds ENTRIES and never wraps.

Reset
REQ-031 reset=1 forces: FSM to RUN, starve_cnt=0, all valid bits cleared, valid_count=0, rd_valid=0, rd_hit=0, tag_err=0, flushing=0.
REQ-032 While reset=1, wr_ack, rd_ack, pcache_write and prim_tag are 0.
REQ-033 Reset asserted mid-FLUSH or the cycle after a read grant drops any pending rd_valid or tag_err pulse.

Configuration
REQ-034 With macro PCACHE_VALID_TRACK_EN defined, valid bits, valid_count and rd_hit behave as in REQ-020, REQ-026 and REQ-028.
REQ-035 With PCACHE_VALID_TRACK_EN undefined, no valid-bit storage is built, rd_hit=1 whenever rd_valid=1, valid_count=0, and flush still drives the FSM and blocks grants.

Verification
REQ-036 Write only: wr_req=1, wr_tag=5 -> same-cycle wr_ack=1, pcache_write=1, prim_tag=5; next cycle valid_count=1.
REQ-037 Contention: wr_req and rd_req held high with STARVE_LIMIT=3 -> grants R,R,R,W,R,R,R,W.
REQ-038 Read-after-write: write tag 7, then read tag 7 -> rd_valid=1 and rd_hit=1 two cycles after the write grant; a read of unwritten tag 8 -> rd_hit=0 (macro defined).
REQ-039 Bad tag: wr_tag=600 -> wr_ack=1, pcache_write=0, tag_err=1 one cycle later, valid_count unchanged.
REQ-040 Flush with both requests high -> no grant that cycle, flushing=1 for 1 cycle, valid_count=0, grants resume in the cycle after.
REQ-041 Rewrite of tag 3 three times -> valid_count=1; reset mid-sequence -> all outputs at their reset values next cycle.

Source files
------------

// File: rtl/pcache_arb.sv
// pcache_arb: one writer and one reader share a parameter cache, with write-starvation protection and a tile-start flush.
// Build option: define PCACHE_VALID_TRACK_EN to build per-entry valid bits, valid_count and real rd_hit tracking.
module pcache_arb #(
  parameter int ENTRIES      = 512,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        wr_req,
  input  logic [11:0] wr_tag,
  output logic        wr_ack,
  input  logic        rd_req,
  input  logic [11:0] rd_tag,
  output logic        rd_ack,
  output logic [11:0] prim_tag,
  output logic        pcache_write,
  output logic        rd_valid,
  output logic        rd_hit,
  output logic        tag_err,
  output logic [9:0]  valid_count,
  output logic        flushing
);
  localparam int            SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);
  localparam logic [11:0]   TAG_LIMIT  = 12'(ENTRIES);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [9:0]    count_q, count_d;
  logic          rd_valid_q, rd_hit_q, tag_err_q;
  logic          wr_gnt, rd_gnt, tag_ok, entry_valid;
  logic [11:0]   sel_tag;

  // Grant selection, shared-address mux, starvation counter and FSM next state.
  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (!reset && (state_q == RUN) && !flush) begin
      if (wr_req && (!rd_req || (starve_q == STARVE_MAX))) begin
        wr_gnt = 1'b1;
      end else if (rd_req) begin
        rd_gnt = 1'b1;
      end else begin
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
      end
    end else begin
      wr_gnt = 1'b0;
      rd_gnt = 1'b0;
    end

    if (wr_gnt) begin
      sel_tag = wr_tag;
    end else if (rd_gnt) begin
      sel_tag = rd_tag;
    end else begin
      sel_tag = 12'd0;
    end
    tag_ok = (sel_tag < TAG_LIMIT);

    // A waiting writer only accumulates starvation while reads keep winning.
    if (wr_gnt || !wr_req) begin
      starve_d = {SW{1'b0}};
    end else if (rd_gnt) begin
      starve_d = starve_q + STARVE_ONE;
    end else begin
      starve_d = starve_q;
    end

    case (state_q)
      RUN:     state_d = flush ? FLUSH : RUN;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign wr_ack       = wr_gnt;
  assign rd_ack       = rd_gnt;
  assign prim_tag     = sel_tag;
  assign pcache_write = wr_gnt && tag_ok;

`ifdef PCACHE_VALID_TRACK_EN
  localparam int IW = (ENTRIES < 2) ? 1 : $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [IW-1:0]      wr_idx, rd_idx;

  assign wr_idx = wr_tag[IW-1:0];
  assign rd_idx = rd_tag[IW-1:0];

  // Valid-bit and population-count update; out-of-range tags never touch the array.
  always_comb begin
    valid_d     = valid_q;
    count_d     = count_q;
    entry_valid = 1'b0;
    if (state_q == FLUSH) begin
      valid_d = '0;
      count_d = 10'd0;
    end else if (pcache_write) begin
      valid_d[wr_idx] = 1'b1;
      if (!valid_q[wr_idx]) begin
        count_d = count_q + 10'd1;
      end else begin
        count_d = count_q;
      end
    end else begin
      valid_d = valid_q;
      count_d = count_q;
    end

    if (rd_gnt && tag_ok) begin
      entry_valid = valid_q[rd_idx];
    end else begin
      entry_valid = 1'b0;
    end
  end

  // Valid-bit storage.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end
`else
  assign count_d     = 10'd0;
  assign entry_valid = 1'b1;
`endif

  // FSM state and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      starve_q   <= {SW{1'b0}};
      count_q    <= 10'd0;
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
      tag_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      count_q    <= count_d;
      rd_valid_q <= rd_gnt;
      rd_hit_q   <= rd_gnt && entry_valid;
      tag_err_q  <= (wr_gnt || rd_gnt) && !tag_ok;
    end
  end

  assign rd_valid    = rd_valid_q;
  assign rd_hit      = rd_hit_q;
  assign tag_err     = tag_err_q;
  assign valid_count = count_q;
  assign flushing    = (state_q == FLUSH);

endmodule

// File: tb/tb_pcache_arb.sv
// tb_pcache_arb: directed scenarios plus randomized requesters, checked against a behavioural cache/arbiter model.
module tb_pcache_arb;
  localparam int ENTRIES      = 512;
  localparam int STARVE_LIMIT = 3;

  logic        clock = 1'b0;
  logic        reset, flush, wr_req, rd_req;
  logic [11:0] wr_tag, rd_tag;
  logic        wr_ack, rd_ack, pcache_write, rd_valid, rd_hit, tag_err, flushing;
  logic [11:0] prim_tag;
  logic [9:0]  valid_count;

  pcache_arb #(.ENTRIES(ENTRIES), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .wr_req(wr_req), .wr_tag(wr_tag), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_tag(rd_tag), .rd_ack(rd_ack),
    .prim_tag(prim_tag), .pcache_write(pcache_write),
    .rd_valid(rd_valid), .rd_hit(rd_hit), .tag_err(tag_err),
    .valid_count(valid_count), .flushing(flushing)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: which entries hold data, how long the writer has waited, and pending registered results.
  bit valid_m [ENTRIES];
  bit m_flush;
  int m_starve;
  bit m_rv, m_hit, m_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int count_valid();
    int n = 0;
    foreach (valid_m[i]) n += valid_m[i];
    return n;
  endfunction

  function automatic logic [11:0] rand_tag();
    int r = $urandom_range(0, 9);
    if (r < 6)      return 12'($urandom_range(0, 15));
    else if (r < 8) return 12'($urandom_range(0, ENTRIES - 1));
    else            return 12'($urandom_range(ENTRIES, 4095));
  endfunction

  // One clock cycle: check same-cycle grants, advance the model, check registered outputs after the edge.
  task automatic cycle(output bit gw, output bit gr);
    bit          ew, er, ok, hv;
    logic [11:0] et;
    #1;
    ew = 1'b0;
    er = 1'b0;
    if (!reset && !m_flush && !flush) begin
      if (wr_req && (!rd_req || m_starve == STARVE_LIMIT)) ew = 1'b1;
      else if (rd_req) er = 1'b1;
    end
    et = ew ? wr_tag : (er ? rd_tag : 12'd0);
    ok = (int'(et) < ENTRIES);
    check_eq("wr_ack", wr_ack, ew);
    check_eq("rd_ack", rd_ack, er);
    check_eq("prim_tag", prim_tag, et);
    check_eq("pcache_write", pcache_write, ew && ok);
    gw = ew;
    gr = er;

    if (reset) begin
      foreach (valid_m[i]) valid_m[i] = 1'b0;
      m_flush  = 1'b0;
      m_starve = 0;
      m_rv     = 1'b0;
      m_hit    = 1'b0;
      m_err    = 1'b0;
    end else begin
      hv = 1'b1;
`ifdef PCACHE_VALID_TRACK_EN
      if (ok) hv = valid_m[et];
      else    hv = 1'b0;
`endif
      m_rv  = er;
      m_hit = er && hv;
      m_err = (ew || er) && !ok;
      if (m_flush) foreach (valid_m[i]) valid_m[i] = 1'b0;
      else if (ew && ok) valid_m[et] = 1'b1;
      if (ew || !wr_req) m_starve = 0;
      else if (er) m_starve++;
      m_flush = !m_flush && flush;
    end

    @(posedge clock);
    #1;
    check_eq("rd_valid", rd_valid, m_rv);
    check_eq("rd_hit", rd_hit, m_hit);
    check_eq("tag_err", tag_err, m_err);
    check_eq("flushing", flushing, m_flush);
`ifdef PCACHE_VALID_TRACK_EN
    check_eq("valid_count", valid_count, count_valid());
`else
    check_eq("valid_count", valid_count, 0);
`endif
  endtask

  initial begin
    bit       gw, gr;
    bit [7:0] seq;
    reset = 1'b1; flush = 1'b0;
    wr_req = 1'b0; rd_req = 1'b0; wr_tag = 12'd0; rd_tag = 12'd0;
    cycle(gw, gr);
    cycle(gw, gr);
    reset = 1'b0;
    cycle(gw, gr);

    // Write-only request to tag 5.
    wr_req = 1'b1; wr_tag = 12'd5;
    cycle(gw, gr);
    check_eq("w5_ack", gw, 1);
`ifdef PCACHE_VALID_TRACK_EN
    check_eq("w5_count", valid_count, 1);
`endif
    wr_req = 1'b0;
    cycle(gw, gr);

    // Sustained contention: three reads then one write, repeating.
    wr_req = 1'b1; wr_tag = 12'd20; rd_req = 1'b1; rd_tag = 12'd21;
    seq = 8'd0;
    for (int i = 0; i < 8; i++) begin
      cycle(gw, gr);
      seq = {seq[6:0], gw};
    end
    check_eq("contention_seq", seq, 8'b0001_0001);
    wr_req = 1'b0; rd_req = 1'b0;
    cycle(gw, gr);

    // Read-after-write of tag 7, then a read of never-written tag 8.
    wr_req = 1'b1; wr_tag = 12'd7;
    cycle(gw, gr);
    wr_req = 1'b0; rd_req = 1'b1; rd_tag = 12'd7;
    cycle(gw, gr);
    check_eq("raw_valid", rd_valid, 1);
    check_eq("raw_hit", rd_hit, 1);
    rd_tag = 12'd8;
    cycle(gw, gr);
`ifdef PCACHE_VALID_TRACK_EN
    check_eq("miss_hit", rd_hit, 0);
`else
    check_eq("miss_hit", rd_hit, 1);
`endif
    rd_req = 1'b0;

    // Out-of-range write tag.
    wr_req = 1'b1; wr_tag = 12'd600;
    cycle(gw, gr);
    check_eq("bad_tag_err", tag_err, 1);

    // Flush with both requesters waiting.
    wr_tag = 12'd9; rd_req = 1'b1; rd_tag = 12'd10; flush = 1'b1;
    cycle(gw, gr);
    check_eq("flush_nogrant", gw || gr, 0);
    check_eq("flush_state", flushing, 1);
    flush = 1'b0;
    cycle(gw, gr);
    check_eq("flush_cnt", valid_count, 0);
    cycle(gw, gr);
    check_eq("flush_resume", gr, 1);
    wr_req = 1'b0; rd_req = 1'b0;

    // Rewrite tag 3 three times, then reset in the middle of traffic.
    reset = 1'b1;
    cycle(gw, gr);
    reset = 1'b0;
    wr_req = 1'b1; wr_tag = 12'd3;
    for (int i = 0; i < 3; i++) cycle(gw, gr);
`ifdef PCACHE_VALID_TRACK_EN
    check_eq("rewrite_cnt", valid_count, 1);
`endif
    rd_req = 1'b1; rd_tag = 12'd3;
    cycle(gw, gr);
    reset = 1'b1;
    cycle(gw, gr);
    check_eq("midrst_valid", rd_valid, 0);
    reset = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    cycle(gw, gr);

    // Randomized requesters honouring the hold-until-ack protocol.
    gw = 1'b0; gr = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!wr_req || gw) begin
        wr_req = ($urandom_range(0, 2) != 0);
        wr_tag = rand_tag();
      end
      if (!rd_req || gr) begin
        rd_req = ($urandom_range(0, 2) != 0);
        rd_tag = rand_tag();
      end
      flush = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 199) == 0);
      cycle(gw, gr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
